// File: rtl/timer_pkg.sv
// Shared definitions for the min:sec timer controller: FSM state encoding,
// default moduli and the wrap-around field step helper.
package timer_pkg;

    localparam int STATE_W     = 3;
    localparam int MAX_SEC_DEF = 60;
    localparam int MAX_MIN_DEF = 60;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PAUSE   = 3'd2,
        S_SET_MIN = 3'd3,
        S_SET_SEC = 3'd4
    } state_t;

    // One user edit step on a field that counts 0..last with wrap in both directions.
    function automatic logic [7:0] step_wrap(input logic [7:0] v,
                                             input logic [7:0] last,
                                             input logic       up);
        logic [7:0] r;
        if (up) r = (v == last)  ? 8'd0 : v + 8'd1;
        else    r = (v == 8'd0)  ? last : v - 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, holds otherwise,
// and flags the terminal count so the owner can advance its seconds field.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                 CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/clear/set controller for the min:sec timer with per-second and
// per-minute pulses. Optional lap capture is enabled by defining LAP_CAPTURE_EN.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_SEC  = MAX_SEC_DEF,
    parameter int MAX_MIN  = MAX_MIN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_run,
    input  logic               btn_clear,
    input  logic               btn_mode,
    input  logic               btn_up,
    input  logic               btn_down,
`ifdef LAP_CAPTURE_EN
    input  logic               btn_lap,
`endif
    output logic [7:0]         sec,
    output logic [7:0]         min,
    output logic               sec_tick,
    output logic               min_carry,
    output logic               running,
    output logic [STATE_W-1:0] state
);

    localparam logic [7:0] SEC_LAST = 8'(MAX_SEC - 1);
    localparam logic [7:0] MIN_LAST = 8'(MAX_MIN - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_sec;
    logic [7:0] r_min;
    logic [7:0] w_sec_next;
    logic [7:0] w_min_next;
    logic       r_sec_tick;
    logic       r_min_carry;
    logic       w_carry;
    logic       w_tick;
    logic       w_tick_apply;
    logic       w_presc_clr;
    logic       w_adjust;

    // Leaving SET_SEC restarts the second from zero so the edited value gets a full second.
    assign w_presc_clr  = btn_clear || ((r_state == S_SET_SEC) && btn_mode);
    assign w_tick_apply = w_tick && !btn_clear;
    assign w_adjust     = !btn_clear && !btn_mode && !btn_run && (btn_up || btn_down);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state == S_RUN),
        .clr  (w_presc_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (btn_clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_PAUSE: begin
                    if (btn_mode)     w_state_next = S_SET_MIN;
                    else if (btn_run) w_state_next = S_RUN;
                end
                S_RUN: begin
                    if (btn_run)      w_state_next = S_PAUSE;
                end
                S_SET_MIN: begin
                    if (btn_mode)     w_state_next = S_SET_SEC;
                end
                S_SET_SEC: begin
                    if (btn_mode)     w_state_next = S_PAUSE;
                end
                default:              w_state_next = S_IDLE;
            endcase
        end
    end

    // A tick only occurs in RUN and edits only in SET_*, so the two never collide.
    always_comb begin
        w_sec_next = r_sec;
        w_min_next = r_min;
        w_carry    = 1'b0;
        if (btn_clear) begin
            w_sec_next = '0;
            w_min_next = '0;
        end else if (w_tick_apply) begin
            if (r_sec == SEC_LAST) begin
                w_sec_next = '0;
                w_carry    = 1'b1;
                w_min_next = (r_min == MIN_LAST) ? 8'd0 : r_min + 8'd1;
            end else begin
                w_sec_next = r_sec + 8'd1;
            end
        end else if (w_adjust) begin
            if (r_state == S_SET_MIN) begin
                w_min_next = step_wrap(r_min, MIN_LAST, btn_up);
            end else if (r_state == S_SET_SEC) begin
                w_sec_next = step_wrap(r_sec, SEC_LAST, btn_up);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec       <= '0;
            r_min       <= '0;
            r_sec_tick  <= 1'b0;
            r_min_carry <= 1'b0;
        end else begin
            r_sec       <= w_sec_next;
            r_min       <= w_min_next;
            r_sec_tick  <= w_tick_apply;
            r_min_carry <= w_carry;
        end
    end

`ifdef LAP_CAPTURE_EN
    logic       r_lap_act;
    logic [7:0] r_lap_sec;
    logic [7:0] r_lap_min;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_act <= 1'b0;
            r_lap_sec <= '0;
            r_lap_min <= '0;
        end else if (btn_clear || (w_state_next != S_RUN)) begin
            r_lap_act <= 1'b0;
        end else if (btn_lap && (r_state == S_RUN)) begin
            r_lap_act <= !r_lap_act;
            if (!r_lap_act) begin
                r_lap_sec <= r_sec;
                r_lap_min <= r_min;
            end
        end
    end

    assign sec = r_lap_act ? r_lap_sec : r_sec;
    assign min = r_lap_act ? r_lap_min : r_min;
`else
    assign sec = r_sec;
    assign min = r_min;
`endif

    assign sec_tick  = r_sec_tick;
    assign min_carry = r_min_carry;
    assign running   = (r_state == S_RUN);
    assign state     = r_state;

endmodule
